// File: rtl/efb_spi_wb_host_if.sv
// ---------------------------------------------------------------------------
// efb_spi_wb_host_if
// Wishbone link between efb_spi_wb_host (initiator) and the EFB hard block
// (SPI slave + UFM). Signal names keep the initiator's point of view.
//   wb_cyc_o  : cycle          (initiator -> EFB)
//   wb_stb_o  : strobe         (initiator -> EFB)
//   wb_we_o   : write enable   (initiator -> EFB)
//   wb_adr_o  : EFB register address, 8 bits
//   wb_dat_o  : write data, 8 bits
//   wb_dat_i  : read data, 8 bits (EFB -> initiator)
//   wb_ack_i  : acknowledge      (EFB -> initiator)
// ---------------------------------------------------------------------------
interface efb_spi_wb_host_if;
    logic       wb_cyc_o;
    logic       wb_stb_o;
    logic       wb_we_o;
    logic [7:0] wb_adr_o;
    logic [7:0] wb_dat_o;
    logic [7:0] wb_dat_i;
    logic       wb_ack_i;

    modport master (
        output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o,
        input  wb_dat_i, wb_ack_i
    );

    modport slave (
        input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o,
        output wb_dat_i, wb_ack_i
    );
endinterface

// File: rtl/efb_spi_wb_host.sv
// ---------------------------------------------------------------------------
// efb_spi_wb_host
// Wishbone initiator for the EFB SPI slave. Writes SPICR1/SPICR2 once, then
// polls SPISR forever: received bytes are drained from SPIRXDR onto a
// streaming rx output, a queued tx byte is written to SPITXDR when the EFB
// reports TRDY.
// Ports:
//   wb_clk_i / wb_rst_i : clock, asynchronous active-high reset
//   wb                  : Wishbone master modport toward the EFB
//   tx_data/tx_valid/tx_ready : one-byte holding register handshake
//   rx_data/rx_valid    : received byte, one-cycle valid pulse (no backpressure)
//   rx_ovf              : pulse when SPISR.ROE is read as 1
//   bus_err             : pulse on an ack timeout
//   init_done           : both control-register writes acknowledged
// ---------------------------------------------------------------------------
module efb_spi_wb_host #(
    parameter logic [7:0]  SPICR1_VAL  = 8'h80,
    parameter logic [7:0]  SPICR2_VAL  = 8'h00,
    parameter int unsigned ACK_TIMEOUT = 16,   // 2..255
    parameter int unsigned POLL_GAP    = 0     // 0..255
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    efb_spi_wb_host_if.master wb,
    input  logic [7:0]        tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [7:0]        rx_data,
    output logic              rx_valid,
    output logic              rx_ovf,
    output logic              bus_err,
    output logic              init_done
);
    localparam logic [7:0] ADR_SPICR1  = 8'h55;
    localparam logic [7:0] ADR_SPICR2  = 8'h56;
    localparam logic [7:0] ADR_SPITXDR = 8'h59;
    localparam logic [7:0] ADR_SPISR   = 8'h5A;
    localparam logic [7:0] ADR_SPIRXDR = 8'h5B;

    localparam logic [7:0] TO_LAST = 8'(ACK_TIMEOUT - 1);
    localparam logic [7:0] GAP     = 8'(POLL_GAP);

    typedef enum logic [2:0] {
        INIT_CR1,
        INIT_CR2,
        POLL_WAIT,
        RD_SR,
        RD_RX,
        WR_TX
    } state_t;

    state_t     r_state;
    logic       r_cyc;
    logic       r_we;
    logic [7:0] r_adr;
    logic [7:0] r_dat_o;
    logic [7:0] r_to_cnt;
    logic [7:0] r_poll_cnt;
    logic       r_trdy;        // TRDY from the last SPISR read
    logic [7:0] r_tx_hold;
    logic       r_tx_full;
    logic [7:0] r_rx_data;
    logic       r_rx_valid;
    logic       r_rx_ovf;
    logic       r_bus_err;
    logic       r_init_done;

    logic       w_accept;
    logic       w_timeout;
    logic       w_req_we;
    logic [7:0] w_req_adr;
    logic [7:0] w_req_dat;

    assign wb.wb_cyc_o = r_cyc;
    assign wb.wb_stb_o = r_cyc;    // single transfers: strobe tracks cycle
    assign wb.wb_we_o  = r_we;
    assign wb.wb_adr_o = r_adr;
    assign wb.wb_dat_o = r_dat_o;

    assign tx_ready  = r_init_done & ~r_tx_full;
    assign rx_data   = r_rx_data;
    assign rx_valid  = r_rx_valid;
    assign rx_ovf    = r_rx_ovf;
    assign bus_err   = r_bus_err;
    assign init_done = r_init_done;

    assign w_accept  = tx_valid & tx_ready;
    assign w_timeout = r_cyc & ~wb.wb_ack_i & (r_to_cnt == TO_LAST);

    // Transfer that the current state issues when it opens a cycle.
    always_comb begin
        // NOTE: every output gets a default first so no latch is inferred.
        w_req_we  = 1'b0;
        w_req_adr = ADR_SPISR;
        w_req_dat = 8'h00;
        case (r_state)
            INIT_CR1: begin
                w_req_we  = 1'b1;
                w_req_adr = ADR_SPICR1;
                w_req_dat = SPICR1_VAL;
            end
            INIT_CR2: begin
                w_req_we  = 1'b1;
                w_req_adr = ADR_SPICR2;
                w_req_dat = SPICR2_VAL;
            end
            RD_RX:    w_req_adr = ADR_SPIRXDR;
            WR_TX: begin
                w_req_we  = 1'b1;
                w_req_adr = ADR_SPITXDR;
                w_req_dat = r_tx_hold;
            end
            default: ;
        endcase
    end

    // NOTE: non-blocking assignments for all state so every register samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state     <= INIT_CR1;
            r_cyc       <= 1'b0;
            r_we        <= 1'b0;
            r_adr       <= 8'h00;
            r_dat_o     <= 8'h00;
            r_to_cnt    <= 8'h00;
            r_poll_cnt  <= 8'h00;
            r_trdy      <= 1'b0;
            r_tx_hold   <= 8'h00;
            r_tx_full   <= 1'b0;
            r_rx_data   <= 8'h00;
            r_rx_valid  <= 1'b0;
            r_rx_ovf    <= 1'b0;
            r_bus_err   <= 1'b0;
            r_init_done <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            r_rx_ovf   <= 1'b0;
            r_bus_err  <= 1'b0;

            // Holding register can never be emptied on an accept edge,
            // because accept requires it to be empty already.
            if (w_accept) begin
                r_tx_hold <= tx_data;
                r_tx_full <= 1'b1;
            end

            if (r_state == POLL_WAIT) begin
                if (r_poll_cnt == GAP) begin
                    r_poll_cnt <= 8'h00;
                    r_state    <= RD_SR;
                end else begin
                    r_poll_cnt <= r_poll_cnt + 8'd1;
                end
            end else if (!r_cyc) begin
                // Every bus state enters with cyc low, which guarantees the
                // idle cycle between transfers.
                r_cyc    <= 1'b1;
                r_we     <= w_req_we;
                r_adr    <= w_req_adr;
                r_dat_o  <= w_req_dat;
                r_to_cnt <= 8'h00;
            end else if (wb.wb_ack_i) begin
                r_cyc   <= 1'b0;
                r_state <= POLL_WAIT;
                case (r_state)
                    INIT_CR1: r_state <= INIT_CR2;
                    INIT_CR2: r_init_done <= 1'b1;
                    RD_SR: begin
                        r_trdy <= wb.wb_dat_i[4];
                        if (wb.wb_dat_i[1]) r_rx_ovf <= 1'b1;
                        if (wb.wb_dat_i[3])
                            r_state <= RD_RX;
                        else if (wb.wb_dat_i[4] && r_tx_full)
                            r_state <= WR_TX;
                    end
                    RD_RX: begin
                        r_rx_data  <= wb.wb_dat_i;
                        r_rx_valid <= 1'b1;
                        if (r_trdy && r_tx_full) r_state <= WR_TX;
                    end
                    WR_TX:   r_tx_full <= 1'b0;
                    default: ;
                endcase
            end else if (w_timeout) begin
                // Init writes are retried in place; polling transfers are
                // abandoned without touching any data.
                r_cyc     <= 1'b0;
                r_bus_err <= 1'b1;
                if (r_state != INIT_CR1 && r_state != INIT_CR2)
                    r_state <= POLL_WAIT;
            end else begin
                r_to_cnt <= r_to_cnt + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_efb_spi_wb_host.sv
// ---------------------------------------------------------------------------
// tb_efb_spi_wb_host
// Bench for efb_spi_wb_host: an EFB model that acks two cycles after stb,
// returns SPISR values from a queue (empty queue reads as 8'h00) and a fixed
// SPIRXDR value. Acked transfers are logged, except idle SPISR reads of 00.
// ---------------------------------------------------------------------------
module tb_efb_spi_wb_host;
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ovf;
    logic       bus_err;
    logic       init_done;

    efb_spi_wb_host_if bus();

    efb_spi_wb_host #(
        .SPICR1_VAL (8'h80),
        .SPICR2_VAL (8'h00),
        .ACK_TIMEOUT(16),
        .POLL_GAP   (0)
    ) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .wb       (bus),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ovf   (rx_ovf),
        .bus_err  (bus_err),
        .init_done(init_done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- EFB model and monitor ----------------
    logic [7:0]  sr_q[$];
    logic [16:0] log_q[$];
    logic [7:0]  rxdr_val  = 8'h00;
    logic        noack_en  = 1'b0;
    logic [7:0]  noack_adr = 8'h00;
    int          ack_cnt   = 0;
    int          rxv_cnt   = 0;
    int          ovf_cnt   = 0;
    int          berr_cnt  = 0;
    logic        p_cyc = 1'b0, p_ack = 1'b0, p_we = 1'b0;
    logic [7:0]  p_adr = 8'h00, p_dat = 8'h00;

    always @(negedge clk) begin
        if (!rst) begin
            if (rx_valid) rxv_cnt++;
            if (rx_ovf)   ovf_cnt++;
            if (bus_err)  berr_cnt++;
            if (bus.wb_cyc_o || bus.wb_stb_o)
                check("stb_eq_cyc", {31'd0, bus.wb_stb_o}, {31'd0, bus.wb_cyc_o});
            if (p_cyc && !p_ack && bus.wb_cyc_o)
                check("bus_stable", {15'd0, bus.wb_we_o, bus.wb_adr_o, bus.wb_dat_o},
                      {15'd0, p_we, p_adr, p_dat});
            if (p_cyc && p_ack)
                check("idle_gap", {31'd0, bus.wb_cyc_o}, 32'd0);
        end

        if (bus.wb_ack_i) begin
            bus.wb_ack_i = 1'b0;
            bus.wb_dat_i = 8'h00;
            ack_cnt      = 0;
        end else if (bus.wb_cyc_o && bus.wb_stb_o) begin
            ack_cnt++;
            if (ack_cnt >= 2 && !(noack_en && bus.wb_adr_o == noack_adr)) begin
                bus.wb_ack_i = 1'b1;
                if (!bus.wb_we_o) begin
                    if (bus.wb_adr_o == 8'h5A)
                        bus.wb_dat_i = (sr_q.size() > 0) ? sr_q.pop_front() : 8'h00;
                    else if (bus.wb_adr_o == 8'h5B)
                        bus.wb_dat_i = rxdr_val;
                    else
                        bus.wb_dat_i = 8'h00;
                end
                if (bus.wb_we_o)
                    log_q.push_back({1'b1, bus.wb_adr_o, bus.wb_dat_o});
                else if (!(bus.wb_adr_o == 8'h5A && bus.wb_dat_i == 8'h00))
                    log_q.push_back({1'b0, bus.wb_adr_o, bus.wb_dat_i});
            end
        end else begin
            ack_cnt = 0;
        end

        p_cyc = bus.wb_cyc_o;
        p_ack = bus.wb_ack_i;
        p_we  = bus.wb_we_o;
        p_adr = bus.wb_adr_o;
        p_dat = bus.wb_dat_o;
    end

    // ---------------- vectors ----------------
    typedef struct packed {
        logic [7:0]       sr;
        logic [7:0]       rxdr;
        logic             tx_en;
        logic [7:0]       tx_byte;
        logic [1:0]       n_log;
        logic [2:0][16:0] exp_log;
        logic [1:0]       exp_rxv;
        logic [7:0]       exp_rx_data;
        logic [1:0]       exp_ovf;
        logic             exp_tx_ready;
    } vec_t;

    localparam logic [16:0] NONE = 17'h0;

    function automatic logic [16:0] rd(input logic [7:0] a, input logic [7:0] d);
        return {1'b0, a, d};
    endfunction

    function automatic logic [16:0] wr(input logic [7:0] a, input logic [7:0] d);
        return {1'b1, a, d};
    endfunction

    function automatic vec_t mkvec(input logic [7:0] sr, input logic [7:0] rxdr,
                                   input logic tx_en, input logic [7:0] txb,
                                   input logic [1:0] n, input logic [16:0] e0,
                                   input logic [16:0] e1, input logic [16:0] e2,
                                   input logic [1:0] rxv, input logic [7:0] rxd,
                                   input logic [1:0] ovf, input logic txr);
        vec_t v;
        v.sr = sr; v.rxdr = rxdr; v.tx_en = tx_en; v.tx_byte = txb;
        v.n_log = n; v.exp_log[0] = e0; v.exp_log[1] = e1; v.exp_log[2] = e2;
        v.exp_rxv = rxv; v.exp_rx_data = rxd; v.exp_ovf = ovf; v.exp_tx_ready = txr;
        return v;
    endfunction

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic offer(input logic [7:0] b);
        for (int i = 0; i < 200 && !tx_ready; i++) tick();
        check("tx_ready_wait", {31'd0, tx_ready}, 32'd1);
        tx_data  = b;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        check("tx_ready_fall", {31'd0, tx_ready}, 32'd0);
    endtask

    task automatic check_log(input string tag, input int n, input logic [2:0][16:0] exp);
        check({tag, "_nlog"}, log_q.size(), n);
        for (int i = 0; i < n && i < log_q.size(); i++)
            check($sformatf("%s_log%0d", tag, i), {15'd0, log_q[i]}, {15'd0, exp[i]});
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        rxdr_val = v.rxdr;
        if (v.tx_en) offer(v.tx_byte);
        log_q.delete();
        rxv_cnt = 0;
        ovf_cnt = 0;
        sr_q.push_back(v.sr);
        repeat (40) tick();
        check_log(tag, int'(v.n_log), v.exp_log);
        check({tag, "_rxv"}, rxv_cnt, {30'd0, v.exp_rxv});
        check({tag, "_rxdata"}, {24'd0, rx_data}, {24'd0, v.exp_rx_data});
        check({tag, "_ovf"}, ovf_cnt, {30'd0, v.exp_ovf});
        check({tag, "_txready"}, {31'd0, tx_ready}, {31'd0, v.exp_tx_ready});
    endtask

    // Waits for the next cycle opened on adr, counts how long cyc stays up.
    task automatic measure_timeout(input logic [7:0] adr, input string tag);
        int hi;
        for (int i = 0; i < 200 && bus.wb_cyc_o; i++) tick();
        for (int i = 0; i < 200 && !(bus.wb_cyc_o && bus.wb_adr_o == adr); i++) tick();
        check({tag, "_cyc_seen"}, {31'd0, bus.wb_cyc_o}, 32'd1);
        hi = 0;
        while (bus.wb_cyc_o && hi < 100) begin
            hi++;
            tick();
        end
        noack_en = 1'b0;
        check({tag, "_cyc_len"}, hi, 32'd16);
    endtask

    vec_t vecs[9];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, %0d checks so far", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.wb_ack_i = 1'b0;
        bus.wb_dat_i = 8'h00;
        tx_data      = 8'h00;
        tx_valid     = 1'b0;
        rst          = 1'b0;

        vecs[0] = mkvec(8'h08, 8'hA5, 1'b0, 8'h00, 2'd2, rd(8'h5A, 8'h08), rd(8'h5B, 8'hA5), NONE, 2'd1, 8'hA5, 2'd0, 1'b1);
        vecs[1] = mkvec(8'h00, 8'hA5, 1'b0, 8'h00, 2'd0, NONE, NONE, NONE, 2'd0, 8'hA5, 2'd0, 1'b1);
        vecs[2] = mkvec(8'h18, 8'h11, 1'b1, 8'h7E, 2'd3, rd(8'h5A, 8'h18), rd(8'h5B, 8'h11), wr(8'h59, 8'h7E), 2'd1, 8'h11, 2'd0, 1'b1);
        vecs[3] = mkvec(8'h0A, 8'h5C, 1'b0, 8'h00, 2'd2, rd(8'h5A, 8'h0A), rd(8'h5B, 8'h5C), NONE, 2'd1, 8'h5C, 2'd1, 1'b1);
        vecs[4] = mkvec(8'h02, 8'h5C, 1'b0, 8'h00, 2'd1, rd(8'h5A, 8'h02), NONE, NONE, 2'd0, 8'h5C, 2'd1, 1'b1);
        vecs[5] = mkvec(8'h08, 8'h44, 1'b1, 8'h99, 2'd2, rd(8'h5A, 8'h08), rd(8'h5B, 8'h44), NONE, 2'd1, 8'h44, 2'd0, 1'b0);
        vecs[6] = mkvec(8'h10, 8'h44, 1'b0, 8'h00, 2'd2, rd(8'h5A, 8'h10), wr(8'h59, 8'h99), NONE, 2'd0, 8'h44, 2'd0, 1'b1);
        vecs[7] = mkvec(8'h10, 8'h44, 1'b0, 8'h00, 2'd1, rd(8'h5A, 8'h10), NONE, NONE, 2'd0, 8'h44, 2'd0, 1'b1);
        vecs[8] = mkvec(8'h1A, 8'h0F, 1'b1, 8'h5A, 2'd3, rd(8'h5A, 8'h1A), rd(8'h5B, 8'h0F), wr(8'h59, 8'h5A), 2'd1, 8'h0F, 2'd1, 1'b1);

        // ---- reset state ----
        #1 rst = 1'b1;
        #1;
        check("rst_cyc", {31'd0, bus.wb_cyc_o}, 32'd0);
        check("rst_stb", {31'd0, bus.wb_stb_o}, 32'd0);
        check("rst_outs", {27'd0, init_done, tx_ready, rx_valid, rx_ovf, bus_err}, 32'd0);
        check("rst_rxdata", {24'd0, rx_data}, 32'd0);
        repeat (2) tick();
        rst = 1'b0;

        // ---- init sequence ----
        for (int i = 0; i < 200 && !(bus.wb_ack_i && bus.wb_adr_o == 8'h56); i++) tick();
        check("init_ack56_seen", {31'd0, bus.wb_ack_i}, 32'd1);
        check("init_done_before", {31'd0, init_done}, 32'd0);
        tick();
        check("init_done_after", {31'd0, init_done}, 32'd1);
        check("init_tx_ready", {31'd0, tx_ready}, 32'd1);
        check_log("init", 2, {NONE, wr(8'h56, 8'h00), wr(8'h55, 8'h80)});

        // ---- tx handshake timing ----
        offer(8'h3C);
        log_q.delete();
        sr_q.push_back(8'h10);
        for (int i = 0; i < 200 && !(bus.wb_ack_i && bus.wb_adr_o == 8'h59); i++) tick();
        check("tx3c_ack_seen", {31'd0, bus.wb_ack_i}, 32'd1);
        check("tx3c_ready_at_ack", {31'd0, tx_ready}, 32'd0);
        tick();
        check("tx3c_ready_after", {31'd0, tx_ready}, 32'd1);
        check_log("tx3c", 2, {NONE, wr(8'h59, 8'h3C), rd(8'h5A, 8'h10)});

        // ---- table vectors ----
        for (int i = 0; i < 9; i++) run_vec(vecs[i], $sformatf("v%0d", i));

        // ---- SPISR read timeout ----
        berr_cnt  = 0;
        noack_adr = 8'h5A;
        noack_en  = 1'b1;
        log_q.delete();
        measure_timeout(8'h5A, "to_sr");
        repeat (5) tick();
        check("to_sr_berr", berr_cnt, 32'd1);
        check("to_sr_nolog", log_q.size(), 32'd0);
        run_vec(mkvec(8'h08, 8'h66, 1'b0, 8'h00, 2'd2, rd(8'h5A, 8'h08), rd(8'h5B, 8'h66), NONE, 2'd1, 8'h66, 2'd0, 1'b1), "to_resume");

        // ---- reset in the middle of WR_TX, then SPICR1 timeout ----
        offer(8'hAB);
        log_q.delete();
        sr_q.push_back(8'h10);
        for (int i = 0; i < 200 && !(bus.wb_cyc_o && bus.wb_adr_o == 8'h59); i++) tick();
        check("mid_wr_seen", {31'd0, bus.wb_cyc_o}, 32'd1);
        noack_adr = 8'h55;
        noack_en  = 1'b1;
        rst = 1'b1;
        #1;
        check("mid_rst_cyc", {31'd0, bus.wb_cyc_o}, 32'd0);
        check("mid_rst_stb", {31'd0, bus.wb_stb_o}, 32'd0);
        check("mid_rst_txready", {31'd0, tx_ready}, 32'd0);
        check("mid_rst_init", {31'd0, init_done}, 32'd0);
        repeat (2) tick();
        log_q.delete();
        berr_cnt = 0;
        rst = 1'b0;
        measure_timeout(8'h55, "to_cr1");
        for (int i = 0; i < 200 && !init_done; i++) tick();
        check("reinit_done", {31'd0, init_done}, 32'd1);
        check("to_cr1_berr", berr_cnt, 32'd1);
        check_log("reinit", 2, {NONE, wr(8'h56, 8'h00), wr(8'h55, 8'h80)});
        run_vec(mkvec(8'h10, 8'h00, 1'b0, 8'h00, 2'd1, rd(8'h5A, 8'h10), NONE, NONE, 2'd0, 8'h00, 2'd0, 1'b1), "post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/efb_spi_wb_host.md
Name: efb_spi_wb_host

Overview:
- Wishbone initiator that drives the EFB hard block's Wishbone slave port, which is configured as an SPI slave with UFM enabled.
- Runs a fixed init sequence on the EFB SPI control registers, then continuously polls the SPI status register.
- On each poll it drains received bytes into a streaming rx output and loads queued tx bytes into the EFB transmit register.
- Sits between the EFB wrapper and the application logic; the application never issues Wishbone cycles itself.

Parameters:
- SPICR1_VAL, 8'h80, value written to SPICR1 at init (SPI enable).
- SPICR2_VAL, 8'h00, value written to SPICR2 at init (slave, mode 0, MSB first).
- ACK_TIMEOUT, 16, cycles with cyc asserted and no ack before the cycle is aborted (range 2..255).
- POLL_GAP, 0, idle cycles inserted between consecutive SPISR reads (range 0..255).

Ports:
- wb_clk_i  in  1  single clock for the block and the EFB Wishbone bus.
- wb_rst_i  in  1  reset, asynchronous, active-high.
- wb_cyc_o  out  1  Wishbone cycle.
- wb_stb_o  out  1  Wishbone strobe.
- wb_we_o  out  1  Wishbone write enable.
- wb_adr_o  out  8  EFB register address.
- wb_dat_o  out  8  write data to the EFB.
- wb_dat_i  in  8  read data from the EFB.
- wb_ack_i  in  1  EFB acknowledge.
- tx_data  in  8  byte to send on MISO.
- tx_valid  in  1  tx byte offered.
- tx_ready  out  1  tx holding register empty and init is done.
- rx_data  out  8  last received byte.
- rx_valid  out  1  one-cycle pulse; rx_data is new.
- rx_ovf  out  1  one-cycle pulse when SPISR.ROE (bit 1) is read as 1.
- bus_err  out  1  one-cycle pulse on an ack timeout.
- init_done  out  1  high once both init writes have been acked.

Behaviour:
- Register addresses (fixed): SPICR1 8'h55, SPICR2 8'h56, SPITXDR 8'h59, SPISR 8'h5A, SPIRXDR 8'h5B.
- SPISR bits used: TRDY = bit 4, RRDY = bit 3, ROE = bit 1.
- Reset (async) forces every output to 0 and clears the tx holding register, poll counter, timeout counter and init_done. State becomes INIT_CR1.
- Reset during an open bus cycle drops cyc/stb immediately. No completion of the interrupted cycle is expected.
- Bus cycle rules:
  - Classic single transfer.
  - cyc, stb, we, adr and dat_o are all registered, assert together, and stay stable until the cycle where ack_i = 1.
  - wb_dat_i is captured on the ack cycle.
  - cyc/stb deassert on the next edge.
  - At least one idle cycle with cyc = 0 separates any two transfers.
- Timeout: the counter starts at the cycle in which cyc rises. If the count reaches ACK_TIMEOUT without ack:
  - cyc/stb drop and bus_err pulses.
  - During init, the same init write is retried. Otherwise the FSM goes to POLL_WAIT and no data side effects occur.
- States:
  - INIT_CR1: write SPICR1_VAL; on ack go to INIT_CR2.
  - INIT_CR2: write SPICR2_VAL; on ack set init_done and go to POLL_WAIT.
  - POLL_WAIT: count POLL_GAP idle cycles (0 means leave after one idle cycle), then go to RD_SR.
  - RD_SR: read SPISR; on ack latch the status byte.
    - If ROE = 1, pulse rx_ovf.
    - If RRDY = 1, go to RD_RX (receive has priority).
    - Else if TRDY = 1 and the holding register is full, go to WR_TX.
    - Else go to POLL_WAIT.
  - RD_RX: read SPIRXDR; on ack, rx_data <= wb_dat_i and rx_valid pulses on the following cycle.
    - Then, if the latched TRDY = 1 and the holding register is full, go to WR_TX; else go to POLL_WAIT.
  - WR_TX: write the holding register to SPITXDR; on ack mark the holding register empty. Go to POLL_WAIT.
- tx handshake:
  - tx_ready = init_done and the holding register is empty.
  - A transfer occurs on a clock edge where tx_valid and tx_ready are both 1.
  - tx_ready falls the cycle after acceptance and rises the cycle after the WR_TX ack.
- rx has no backpressure. The consumer must take each rx_valid pulse.
- Simultaneous events:
  - A tx acceptance in the same cycle as the RD_SR ack is not seen by that decision; it is sent on the next poll.
  - rx_ovf and rx_valid may pulse in the same poll round.
- The bus never has more than one outstanding transfer.

Test Plan:
- Reset, then an EFB model that acks 2 cycles after stb -> writes 55<=80 then 56<=00, in that order. init_done = 1 after the second ack. tx_ready = 1 the same cycle.
- SPISR model returns 8'h08, SPIRXDR returns 8'hA5 -> read of 5A, then read of 5B, then rx_data = A5 with a single rx_valid pulse. The next poll returns 8'h00 -> no further rx_valid.
- Offer tx_data = 3C with SPISR = 8'h10 -> tx_ready drops one cycle after acceptance. Write 59<=3C follows the SPISR read. tx_ready rises after its ack.
- SPISR = 8'h18 with tx pending (tx_data = 7E, SPIRXDR = 11) -> order is read 5A, read 5B, write 59<=7E. rx_data = 11.
- Model never acks the SPISR read, ACK_TIMEOUT = 16 -> cyc drops 16 cycles after it rose, bus_err pulses once, polling resumes. A timeout on the SPICR1 write retries 55<=80.
- Assert wb_rst_i mid WR_TX -> cyc/stb/tx_ready/init_done go to 0 asynchronously. After release the init writes repeat. The dropped tx byte is not written.
